// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises core data and fetch accesses onto one memory bus, data first, with an ack watchdog
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [SEL_WIDTH-1:0]  rom_write_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_write_data,
  output logic [DATA_WIDTH-1:0] rom_read_data,
  input  logic                  ram_en,
  input  logic [SEL_WIDTH-1:0]  ram_write_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  stall,
  output logic                  bus_req,
  output logic [SEL_WIDTH-1:0]  bus_write_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  input  logic                  bus_ack,
  output logic                  bus_error
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;
  state_t state;
  logic pend_i;
  logic [CW-1:0] cnt;
  logic abort, done, rd;
  assign stall = state == DATA || state == INST || (state == IDLE && (rom_en || ram_en));
  // an ack in the limit cycle still completes normally
  assign abort = TIMEOUT_CYCLES != 0 && !bus_ack && cnt == LIMIT;
  assign done = bus_ack || abort;
  assign rd = bus_write_en == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_i <= 1'b0;
      cnt <= '0;
      bus_req <= 1'b0;
      bus_write_en <= '0;
      bus_addr <= '0;
      bus_write_data <= '0;
      rom_read_data <= '0;
      ram_read_data <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pend_i <= rom_en;
          cnt <= '0;
          if (ram_en) begin
            state <= DATA;
            bus_req <= 1'b1;
            bus_write_en <= ram_write_en;
            bus_addr <= ram_addr;
            bus_write_data <= ram_write_data;
          end else if (rom_en) begin
            state <= INST;
            bus_req <= 1'b1;
            bus_write_en <= rom_write_en;
            bus_addr <= rom_addr;
            bus_write_data <= rom_write_data;
          end
        end
        DATA: begin
          if (done) begin
            if (rd) ram_read_data <= abort ? '0 : bus_read_data;
            if (abort) bus_error <= 1'b1;
            cnt <= '0;
            // bus_req stays high into INST; the ack strobe separates the two transfers
            if (pend_i) begin
              state <= INST;
              bus_write_en <= rom_write_en;
              bus_addr <= rom_addr;
              bus_write_data <= rom_write_data;
            end else begin
              state <= DONE;
              bus_req <= 1'b0;
            end
          end else cnt <= cnt + CW'(1);
        end
        INST: begin
          if (done) begin
            if (rd) rom_read_data <= abort ? '0 : bus_read_data;
            if (abort) bus_error <= 1'b1;
            cnt <= '0;
            state <= DONE;
            bus_req <= 1'b0;
          end else cnt <= cnt + CW'(1);
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
